// File: rtl/i2c_target_model.sv
// I2C target device model: oversampled SCL/SDA decode and a small
// byte-addressed register file with an auto-incrementing pointer.
module i2c_target_model #(
    parameter logic [6:0]  TargetAddr = 7'h50,
    parameter int unsigned NumRegs    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       scl_i,
    input  logic                       sda_i,
    output logic                       sda_o,
    output logic                       sda_oe,
    output logic                       busy_o,
    output logic                       wr_o,
    output logic [$clog2(NumRegs)-1:0] wr_addr_o,
    output logic [7:0]                 wr_data_o
);

    localparam int unsigned PtrW = $clog2(NumRegs);
    localparam int unsigned CntW = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_e;

    // Synchroniser and history flops
    logic scl_q1, scl_q2, scl_q3;
    logic sda_q1, sda_q2, sda_q3;

    // Decoded bus events, registered
    logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;

    // FSM and datapath state
    state_e            state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic              first_q, first_d;
    logic              sda_oe_d, busy_d, wr_d;
    logic [PtrW-1:0]   wr_addr_d;
    logic [7:0]        wr_data_d;
    logic              reg_we;
    logic [7:0]        regs [NumRegs];
    logic [7:0]        rd_byte;

    assign sda_o   = 1'b0;
    assign rd_byte = regs[ptr_q];

    // Bring asynchronous bus lines into clk_i; idle bus level is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q1 <= 1'b1;
            scl_q2 <= 1'b1;
            scl_q3 <= 1'b1;
            sda_q1 <= 1'b1;
            sda_q2 <= 1'b1;
            sda_q3 <= 1'b1;
        end else begin
            scl_q1 <= scl_i;
            scl_q2 <= scl_q1;
            scl_q3 <= scl_q2;
            sda_q1 <= sda_i;
            sda_q2 <= sda_q1;
            sda_q3 <= sda_q2;
        end
    end

    // Edge and START/STOP decode from synchronised values only
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_bit_q  <= 1'b1;
        end else begin
            scl_rise_q <= scl_q2 & ~scl_q3;
            scl_fall_q <= ~scl_q2 & scl_q3;
            start_q    <= scl_q2 & scl_q3 & sda_q3 & ~sda_q2;
            stop_q     <= scl_q2 & scl_q3 & ~sda_q3 & sda_q2;
            sda_bit_q  <= sda_q2;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            first_q   <= 1'b0;
            sda_oe    <= 1'b0;
            busy_o    <= 1'b0;
            wr_o      <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            first_q   <= first_d;
            sda_oe    <= sda_oe_d;
            busy_o    <= busy_d;
            wr_o      <= wr_d;
            wr_addr_o <= wr_addr_d;
            wr_data_o <= wr_data_d;
        end
    end

    // Register file; reset contents are 0xA0 + index
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs[i] <= 8'hA0 + 8'(i);
            end
        end else if (reg_we) begin
            regs[ptr_q] <= shift_q;
        end
    end

    // Next-state and output decode; START/STOP override any state action
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        sda_oe_d  = sda_oe;
        busy_d    = busy_o;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_o;
        wr_data_d = wr_data_o;
        reg_we    = 1'b0;

        if (start_q) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_q) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (scl_rise_q && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_bit_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_q && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (shift_q[7:1] == TargetAddr) begin
                            sda_oe_d = 1'b1;
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            state_d  = ST_WAIT_STOP;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall_q) begin
                        if (shift_q[0]) begin
                            shift_d   = rd_byte;
                            sda_oe_d  = ~rd_byte[7];
                            bit_cnt_d = 4'd1;
                            state_d   = ST_RD_BYTE;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            first_d   = 1'b1;
                            state_d   = ST_WR_BYTE;
                        end
                    end
                end

                ST_WR_BYTE: begin
                    if (scl_rise_q && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_bit_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_q && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b1;
                        state_d   = ST_WR_ACK;
                        if (first_q) begin
                            ptr_d   = shift_q[PtrW-1:0];
                            first_d = 1'b0;
                        end else begin
                            reg_we    = 1'b1;
                            wr_d      = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = shift_q;
                            ptr_d     = ptr_q + PtrW'(1);
                        end
                    end
                end

                ST_WR_ACK: begin
                    if (scl_fall_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_BYTE;
                    end
                end

                ST_RD_BYTE: begin
                    if (scl_fall_q) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                ST_RD_ACK: begin
                    // bit_cnt marks that the host ACKed on this slot
                    if (scl_rise_q) begin
                        if (sda_bit_q) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            ptr_d     = ptr_q + PtrW'(1);
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall_q && bit_cnt_q == 4'd1) begin
                        shift_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 4'd1;
                        state_d   = ST_RD_BYTE;
                    end
                end

                ST_WAIT_STOP: begin
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_model.sv
// Bench for i2c_target_model: an open-drain I2C host driving directed
// table entries, corner sequences and random transactions against a
// transaction-level model of the register file.
module tb_i2c_target_model;

    localparam int unsigned NR = 16;
    localparam logic [6:0]  TA = 7'h50;
    localparam int          H  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       host_sda;
    logic       sda_bus;
    logic       sda_o, sda_oe, busy, wr;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    assign sda_bus = host_sda & ~sda_oe;

    i2c_target_model #(.TargetAddr(TA), .NumRegs(NR)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .sda_oe    (sda_oe),
        .busy_o    (busy),
        .wr_o      (wr),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          set_ptr;
        logic [6:0]  dev;
        logic [7:0]  ptr;
        int          n;
        logic [23:0] data;
        bit          exp_ack;
        int          exp_nwr;
        logic [23:0] exp_rd;
        logic [35:0] exp_wr;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] wr_q[$];
    logic [7:0]  m_regs[NR];
    int          m_ptr;

    // Record every register-write strobe
    always @(negedge clk) begin
        if (rst_n && wr) wr_q.push_back({wr_addr, wr_data});
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_c();
        host_sda = 1'b1; scl = 1'b1; wt(H);
        host_sda = 1'b0; wt(H);
        scl = 1'b0; wt(2);
        check("busy after START", busy, 1);
    endtask

    task automatic rep_start();
        host_sda = 1'b1; wt(H);
        scl = 1'b1; wt(H);
        host_sda = 1'b0; wt(H);
        scl = 1'b0; wt(2);
    endtask

    task automatic stop_c();
        host_sda = 1'b0; wt(H);
        scl = 1'b1; wt(H);
        host_sda = 1'b1; wt(H);
        check("busy after STOP", busy, 0);
    endtask

    task automatic write_bit(input logic b);
        host_sda = b; wt(H);
        scl = 1'b1; wt(H);
        scl = 1'b0; wt(2);
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        host_sda = 1'b1; wt(H);
        scl = 1'b1; wt(H / 2);
        ack = !sda_bus;
        wt(H / 2);
        scl = 1'b0; wt(2);
    endtask

    task automatic read_byte(input bit ack, output logic [7:0] b);
        b = '0;
        host_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wt(H);
            scl = 1'b1; wt(H / 2);
            b = {b[6:0], sda_bus};
            wt(H / 2);
            scl = 1'b0; wt(2);
        end
        host_sda = ack ? 1'b0 : 1'b1; wt(H);
        scl = 1'b1; wt(H);
        scl = 1'b0; wt(2);
        host_sda = 1'b1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'hA0 + 8'(i);
        m_ptr = 0;
    endfunction

    // Transaction-level prediction; updates the model state
    function automatic vec_t model_apply(input vec_t v);
        vec_t r = v;
        r.exp_nwr = 0; r.exp_wr = '0; r.exp_rd = '0;
        if (!v.rd) begin
            r.exp_ack = (v.dev == TA);
            if (r.exp_ack) begin
                m_ptr = int'(v.ptr) % NR;
                for (int i = 0; i < v.n; i++) begin
                    m_regs[m_ptr] = v.data[8*i +: 8];
                    r.exp_wr[12*i +: 12] = {4'(m_ptr), v.data[8*i +: 8]};
                    r.exp_nwr++;
                    m_ptr = (m_ptr + 1) % NR;
                end
            end
        end else begin
            r.exp_ack = 1'b1;
            if (v.set_ptr) m_ptr = int'(v.ptr) % NR;
            for (int i = 0; i < v.n; i++) begin
                r.exp_rd[8*i +: 8] = m_regs[m_ptr];
                if (i < v.n - 1) m_ptr = (m_ptr + 1) % NR;
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(input bit rd, input bit sp, input logic [6:0] dev,
                                input logic [7:0] ptr, input int n, input logic [23:0] data,
                                input bit ea, input int nwr, input logic [23:0] erd,
                                input logic [35:0] ewr);
        vec_t v;
        v.rd = rd; v.set_ptr = sp; v.dev = dev; v.ptr = ptr; v.n = n; v.data = data;
        v.exp_ack = ea; v.exp_nwr = nwr; v.exp_rd = erd; v.exp_wr = ewr;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        bit         ack;
        logic [7:0] b;
        wr_q.delete();
        if (!v.rd) begin
            start_c();
            write_byte({v.dev, 1'b0}, ack);
            check({tag, " addr ack"}, ack, v.exp_ack);
            write_byte(v.ptr, ack);
            check({tag, " ptr ack"}, ack, v.exp_ack);
            for (int i = 0; i < v.n; i++) begin
                write_byte(v.data[8*i +: 8], ack);
                check($sformatf("%s data%0d ack", tag, i), ack, v.exp_ack);
            end
            stop_c();
            check({tag, " wr count"}, wr_q.size(), v.exp_nwr);
            for (int i = 0; i < v.exp_nwr && i < wr_q.size(); i++)
                check($sformatf("%s wr%0d addr/data", tag, i), wr_q[i], v.exp_wr[12*i +: 12]);
        end else begin
            start_c();
            if (v.set_ptr) begin
                write_byte({v.dev, 1'b0}, ack);
                check({tag, " waddr ack"}, ack, v.exp_ack);
                write_byte(v.ptr, ack);
                check({tag, " ptr ack"}, ack, v.exp_ack);
                rep_start();
            end
            write_byte({v.dev, 1'b1}, ack);
            check({tag, " raddr ack"}, ack, v.exp_ack);
            for (int i = 0; i < v.n; i++) begin
                read_byte(i < v.n - 1, b);
                check($sformatf("%s rd%0d", tag, i), b, v.exp_rd[8*i +: 8]);
            end
            wt(6);
            check({tag, " sda_oe after NACK"}, sda_oe, 0);
            stop_c();
            check({tag, " no wr on read"}, wr_q.size(), 0);
        end
    endtask

    vec_t tbl[6];

    initial begin
        bit         ack;
        int         k;
        vec_t       v;
        int         r;

        tbl[0] = mk(1, 0, TA,    8'h00, 2, 24'h0,      1, 0, 24'h00A1A0, 36'h0);
        tbl[1] = mk(0, 0, TA,    8'h03, 2, 24'h005B5A, 1, 2, 24'h0,      36'h00045B35A);
        tbl[2] = mk(1, 1, TA,    8'h03, 3, 24'h0,      1, 0, 24'hA55B5A, 36'h0);
        tbl[3] = mk(0, 0, 7'h51, 8'h03, 1, 24'h000077, 0, 0, 24'h0,      36'h0);
        tbl[4] = mk(0, 0, TA,    8'h0F, 2, 24'h002211, 1, 2, 24'h0,      36'h000022F11);
        tbl[5] = mk(1, 1, TA,    8'h0F, 2, 24'h0,      1, 0, 24'h002211, 36'h0);

        rst_n = 1'b0; scl = 1'b1; host_sda = 1'b1;
        model_reset();
        wt(5);
        check("reset sda_o", sda_o, 0);
        check("reset sda_oe", sda_oe, 0);
        check("reset busy", busy, 0);
        check("reset wr", wr, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset wr_data", wr_data, 0);
        rst_n = 1'b1;
        wt(H);

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
            void'(model_apply(tbl[i]));
        end

        // STOP after four data bits: no write, bus released, pointer kept
        wr_q.delete();
        start_c();
        write_byte({TA, 1'b0}, ack);
        check("midstop addr ack", ack, 1);
        write_byte(8'h07, ack);
        check("midstop ptr ack", ack, 1);
        for (int i = 0; i < 4; i++) write_bit(i[0]);
        stop_c();
        check("midstop no wr", wr_q.size(), 0);
        check("midstop sda_oe", sda_oe, 0);
        m_ptr = 7;
        v = model_apply(mk(1, 0, TA, 8'h00, 1, 24'h0, 1, 0, 24'h0, 36'h0));
        run_vec(v, "after_midstop");

        // Random transactions against the model
        for (int t = 0; t < 30; t++) begin
            r = $urandom_range(0, 9);
            v = mk(0, 0, TA, 8'($urandom_range(0, 255)), 0, 24'($urandom), 0, 0, 24'h0, 36'h0);
            if (r < 5) begin
                v.n = $urandom_range(0, 3);
            end else if (r < 9) begin
                v.rd = 1'b1;
                v.set_ptr = bit'($urandom_range(0, 1));
                v.n = $urandom_range(1, 3);
            end else begin
                v.dev = TA ^ 7'($urandom_range(1, 127));
                v.n = $urandom_range(0, 2);
            end
            v = model_apply(v);
            run_vec(v, $sformatf("rnd%0d", t));
        end

        // Reset while the target pulls SDA during a read
        v = model_apply(mk(0, 0, TA, 8'h03, 1, 24'h00003C, 1, 0, 24'h0, 36'h0));
        run_vec(v, "pre_reset_wr");
        start_c();
        write_byte({TA, 1'b0}, ack);
        write_byte(8'h03, ack);
        rep_start();
        write_byte({TA, 1'b1}, ack);
        check("rstread addr ack", ack, 1);
        k = 0;
        while (!sda_oe && k < 30) begin
            wt(1);
            k++;
        end
        check("sda_oe driven before reset", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("sda_oe async reset", sda_oe, 0);
        check("busy async reset", busy, 0);
        check("wr async reset", wr, 0);
        host_sda = 1'b1; scl = 1'b1;
        wt(H);
        rst_n = 1'b1;
        wt(H);
        model_reset();
        run_vec(mk(1, 1, TA, 8'h03, 1, 24'h0, 1, 0, 24'h0000A3, 36'h0), "post_reset_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
